// File: rtl/go_kill_ctrl_if.sv
// rtl/go_kill_ctrl_if.sv - Control/status bundle between a job initiator and go_kill_ctrl
//
// Purpose: carries the job request, kill and completion inputs plus the
// go/kill pulses and sticky status outputs of go_kill_ctrl.
// Ports (as seen from the controller, modport slave):
//   start, abort, done_in, kill_clr   : inputs  (1 bit each)
//   go_out, kill_out, busy            : outputs (1 bit each)
//   kill_ltchd, timeout_err           : outputs (1 bit each, sticky)
//   done_cnt                          : output  (8 bits, saturating)
// The master modport is the initiator's view (drives the inputs).

interface go_kill_ctrl_if;
  logic       start;
  logic       abort;
  logic       done_in;
  logic       kill_clr;
  logic       go_out;
  logic       kill_out;
  logic       busy;
  logic       kill_ltchd;
  logic       timeout_err;
  logic [7:0] done_cnt;

  modport slave (
    input  start, abort, done_in, kill_clr,
    output go_out, kill_out, busy, kill_ltchd, timeout_err, done_cnt
  );

  modport master (
    output start, abort, done_in, kill_clr,
    input  go_out, kill_out, busy, kill_ltchd, timeout_err, done_cnt
  );
endinterface

// File: rtl/go_kill_ctrl.sv
// rtl/go_kill_ctrl.sv - Go/kill job controller with WAIT timeout and sticky kill status
//
// Purpose: issues a one-cycle go pulse for each accepted job, waits for the
// downstream completion, and issues a one-cycle kill pulse on abort or when
// the WAIT phase reaches TIMEOUT cycles. Kills are latched until kill_clr.
// Optional feature macro: GO_KILL_CTRL_RETRY_EN (one automatic retry after
// the first timeout of a job; abort never retries).
// Ports:
//   clk      : input, single clock, rising edge
//   reset_n  : input, asynchronous active-low reset
//   bus      : go_kill_ctrl_if.slave (start/abort/done_in/kill_clr in,
//              go_out/kill_out/busy/kill_ltchd/timeout_err/done_cnt out)
// Parameter: TIMEOUT, WAIT-state cycle limit, legal range 2..255.

module go_kill_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  go_kill_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } state_t;

  localparam logic [7:0] LP_TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_timer;
  logic       r_go;
  logic       r_kill;
  logic       r_busy;
  logic       r_kill_ltchd;
  logic       r_timeout_err;
  logic       r_cause_to;     // current KILL was caused by timer expiry
  logic [7:0] r_done_cnt;
`ifdef GO_KILL_CTRL_RETRY_EN
  logic       r_retry_used;   // this job already spent its one retry
  logic       r_retry_kill;   // current KILL is the non-latching retry kill
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_timer       <= 8'd0;
      r_go          <= 1'b0;
      r_kill        <= 1'b0;
      r_busy        <= 1'b0;
      r_kill_ltchd  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cause_to    <= 1'b0;
      r_done_cnt    <= 8'd0;
`ifdef GO_KILL_CTRL_RETRY_EN
      r_retry_used  <= 1'b0;
      r_retry_kill  <= 1'b0;
`endif
    end else begin
      // Clear first so that a latch set later in this block wins.
      if (bus.kill_clr) begin
        r_kill_ltchd  <= 1'b0;
        r_timeout_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start && !r_kill_ltchd) begin
            r_state <= ST_GO;
            r_go    <= 1'b1;
            r_busy  <= 1'b1;
`ifdef GO_KILL_CTRL_RETRY_EN
            r_retry_used <= 1'b0;
`endif
          end
        end

        ST_GO: begin
          r_go    <= 1'b0;
          r_timer <= 8'd0;
          if (bus.abort) begin
            r_state    <= ST_KILL;
            r_kill     <= 1'b1;
            r_cause_to <= 1'b0;
`ifdef GO_KILL_CTRL_RETRY_EN
            r_retry_kill <= 1'b0;
`endif
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Completion has priority over both abort and timer expiry.
          if (bus.done_in) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (r_done_cnt != 8'hFF) begin
              r_done_cnt <= r_done_cnt + 8'd1;
            end
          end else if (bus.abort) begin
            r_state    <= ST_KILL;
            r_kill     <= 1'b1;
            r_cause_to <= 1'b0;
`ifdef GO_KILL_CTRL_RETRY_EN
            r_retry_kill <= 1'b0;
`endif
          end else if (r_timer == LP_TIMER_LAST) begin
            r_state    <= ST_KILL;
            r_kill     <= 1'b1;
            r_cause_to <= 1'b1;
`ifdef GO_KILL_CTRL_RETRY_EN
            r_retry_kill <= !r_retry_used;
            r_retry_used <= 1'b1;
`endif
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        ST_KILL: begin
          r_kill <= 1'b0;
`ifdef GO_KILL_CTRL_RETRY_EN
          if (r_retry_kill) begin
            // Retry: re-issue go without touching the sticky status.
            r_state      <= ST_GO;
            r_go         <= 1'b1;
            r_retry_kill <= 1'b0;
          end else begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_kill_ltchd <= 1'b1;
            if (r_cause_to) begin
              r_timeout_err <= 1'b1;
            end
          end
`else
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_kill_ltchd <= 1'b1;
          if (r_cause_to) begin
            r_timeout_err <= 1'b1;
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
          r_go    <= 1'b0;
          r_kill  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.go_out      = r_go;
  assign bus.kill_out    = r_kill;
  assign bus.busy        = r_busy;
  assign bus.kill_ltchd  = r_kill_ltchd;
  assign bus.timeout_err = r_timeout_err;
  assign bus.done_cnt    = r_done_cnt;

endmodule

// File: tb/tb_go_kill_ctrl.sv
// tb/tb_go_kill_ctrl.sv - Scoreboard testbench for go_kill_ctrl with TIMEOUT=4

module tb_go_kill_ctrl;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   failures;
  bit   run;

  go_kill_ctrl_if bus ();

  go_kill_ctrl #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_kill;
  } pl_t;

  // sig: 0 busy, 1 kill_ltchd, 2 timeout_err, 3 done_cnt
  typedef struct {
    int cyc;
    int sig;
    int val;
  } st_t;

  pl_t pq[$];
  st_t sq[$];
  pl_t mp;
  st_t ms;
  int  mact;

  function automatic string sig_name(int s);
    case (s)
      0:       return "busy";
      1:       return "kill_ltchd";
      2:       return "timeout_err";
      default: return "done_cnt";
    endcase
  endfunction

  task automatic exp_pulse(int c, bit k);
    pl_t p;
    p.cyc = c;
    p.is_kill = k;
    pq.push_back(p);
  endtask

  task automatic exp_st(int c, int s, int v);
    st_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sq.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues on the falling edge.
  always @(negedge clk) begin
    if (run) begin
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        mp = pq.pop_front();
        checks++;
        failures++;
        $display("FAIL pulse_missing at cyc=%0d kind=%s actual=none required=pulse",
                 mp.cyc, mp.is_kill ? "kill" : "go");
      end
      if (bus.go_out || bus.kill_out) begin
        checks++;
        if (bus.go_out && bus.kill_out) begin
          failures++;
          $display("FAIL go_kill_overlap cyc=%0d actual=both required=one", cyc);
        end else if (pq.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected cyc=%0d actual=%s required=none",
                   cyc, bus.kill_out ? "kill" : "go");
        end else begin
          mp = pq.pop_front();
          if (mp.cyc != cyc || mp.is_kill != bus.kill_out) begin
            failures++;
            $display("FAIL pulse_match cyc=%0d actual=%s required=%s@%0d",
                     cyc, bus.kill_out ? "kill" : "go", mp.is_kill ? "kill" : "go", mp.cyc);
          end
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        ms = sq.pop_front();
        checks++;
        if (ms.cyc < cyc) begin
          failures++;
          $display("FAIL status_missed %s cyc=%0d actual=skipped required=%0d",
                   sig_name(ms.sig), ms.cyc, ms.val);
        end else begin
          case (ms.sig)
            0:       mact = int'(bus.busy);
            1:       mact = int'(bus.kill_ltchd);
            2:       mact = int'(bus.timeout_err);
            default: mact = int'(bus.done_cnt);
          endcase
          if (mact != ms.val) begin
            failures++;
            $display("FAIL status_%s cyc=%0d actual=%0d required=%0d",
                     sig_name(ms.sig), cyc, mact, ms.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    checks   = 0;
    failures = 0;
    run      = 1'b1;
    reset_n  = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.done_in  = 1'b0;
    bus.kill_clr = 1'b0;

    // Reset state
    exp_st(1, 0, 0);
    exp_st(1, 1, 0);
    exp_st(1, 2, 0);
    exp_st(1, 3, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Normal job: done_in in cycle 3
    t = cyc;
    exp_pulse(t + 1, 1'b0);
    exp_st(t + 1, 0, 1);
    exp_st(t + 3, 0, 1);
    exp_st(t + 3, 3, 0);
    exp_st(t + 4, 0, 0);
    exp_st(t + 4, 3, 1);
    exp_st(t + 4, 1, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(2);
    bus.done_in = 1'b1;
    tick(1);
    bus.done_in = 1'b0;
    tick(2);

    // abort and done_in together in WAIT: done wins
    t = cyc;
    exp_pulse(t + 1, 1'b0);
    exp_st(t + 3, 0, 0);
    exp_st(t + 3, 3, 2);
    exp_st(t + 3, 1, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(1);
    bus.abort   = 1'b1;
    bus.done_in = 1'b1;
    tick(1);
    bus.abort   = 1'b0;
    bus.done_in = 1'b0;
    tick(2);

`ifdef GO_KILL_CTRL_RETRY_EN
    // Timeout with one retry: two go and two kill pulses, latch after second
    t = cyc;
    exp_pulse(t + 1, 1'b0);
    exp_pulse(t + 6, 1'b1);
    exp_pulse(t + 7, 1'b0);
    exp_pulse(t + 12, 1'b1);
    exp_st(t + 7, 0, 1);
    exp_st(t + 7, 1, 0);
    exp_st(t + 7, 2, 0);
    exp_st(t + 13, 0, 0);
    exp_st(t + 13, 1, 1);
    exp_st(t + 13, 2, 1);
    exp_st(t + 14, 1, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(12);
    bus.kill_clr = 1'b1;
    tick(1);
    bus.kill_clr = 1'b0;
    tick(2);
`else
    // Timeout: WAIT cycles 2-5, kill in 6, latched from 7; clear in KILL loses
    t = cyc;
    exp_pulse(t + 1, 1'b0);
    exp_pulse(t + 6, 1'b1);
    exp_st(t + 5, 0, 1);
    exp_st(t + 6, 0, 1);
    exp_st(t + 6, 1, 0);
    exp_st(t + 7, 0, 0);
    exp_st(t + 7, 1, 1);
    exp_st(t + 7, 2, 1);
    exp_st(t + 8, 0, 0);
    exp_st(t + 8, 1, 1);
    exp_st(t + 10, 1, 0);
    exp_st(t + 10, 2, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(5);
    bus.kill_clr = 1'b1;
    tick(1);
    bus.kill_clr = 1'b0;
    bus.start    = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(1);
    bus.kill_clr = 1'b1;
    tick(1);
    bus.kill_clr = 1'b0;
    tick(2);
`endif

    // abort in GO: kill next cycle, no timeout_err
    t = cyc;
    exp_pulse(t + 1, 1'b0);
    exp_pulse(t + 2, 1'b1);
    exp_st(t + 2, 0, 1);
    exp_st(t + 3, 0, 0);
    exp_st(t + 3, 1, 1);
    exp_st(t + 3, 2, 0);
    exp_st(t + 4, 1, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    tick(1);
    bus.kill_clr = 1'b1;
    tick(1);
    bus.kill_clr = 1'b0;
    tick(2);

    // done_cnt saturation: count is 2 here, 254 more jobs
    for (int j = 0; j < 254; j++) begin
      t = cyc;
      exp_pulse(t + 1, 1'b0);
      if (j >= 251) exp_st(t + 3, 3, (j == 251) ? 254 : 255);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(1);
      bus.done_in = 1'b1;
      tick(1);
      bus.done_in = 1'b0;
    end
    tick(2);

    // Reset mid-WAIT: outputs clear at once, no kill pulse
    t = cyc;
    exp_pulse(t + 1, 1'b0);
    exp_st(t + 2, 0, 1);
    exp_st(t + 3, 0, 0);
    exp_st(t + 3, 1, 0);
    exp_st(t + 3, 2, 0);
    exp_st(t + 3, 3, 0);
    exp_st(t + 6, 0, 0);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(2);
    reset_n = 1'b0;
    tick(5);
    reset_n = 1'b1;
    t2 = cyc;
    exp_pulse(t2 + 1, 1'b0);
    exp_st(t2 + 1, 0, 1);
    exp_st(t2 + 1, 3, 0);
    exp_st(t2 + 3, 3, 1);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(1);
    bus.done_in = 1'b1;
    tick(1);
    bus.done_in = 1'b0;
    tick(3);

    run = 1'b0;
    checks++;
    if (pq.size() != 0 || sq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d/%0d pending required=0/0", pq.size(), sq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/go_kill_ctrl.md
GO_KILL_CTRL -- requirements
Module: go_kill_ctrl

Interface
REQ-001 Parameter TIMEOUT, 16, WAIT-state cycle limit before auto-kill; legal range 2..255.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  job request; sampled in IDLE only.
REQ-005 abort  input  1  software kill request; honoured in GO and WAIT.
REQ-006 done_in  input  1  completion from downstream delay chain; honoured in WAIT only.
REQ-007 kill_clr  input  1  clears kill_ltchd and timeout_err.
REQ-008 go_out  output  1  registered one-cycle go pulse to downstream.
REQ-009 kill_out  output  1  registered one-cycle kill pulse to downstream.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 kill_ltchd  output  1  sticky: a kill was issued and not yet cleared.
REQ-012 timeout_err  output  1  sticky: a kill was caused by timeout.
REQ-013 done_cnt  output  8  count of completed jobs, saturating.

Function
REQ-014 FSM SHALL have states IDLE, GO, WAIT, KILL, all outputs decoded from registers.
REQ-015 IDLE: start=1 and kill_ltchd=0 -> GO; otherwise stay; start while kill_ltchd=1 SHALL be ignored.
REQ-016 GO: go_out=1 for exactly one cycle, timer cleared to 0; abort=1 -> KILL, else -> WAIT.
REQ-017 Latency: start high in IDLE cycle n -> go_out high in cycle n+1, busy high from cycle n+1.
REQ-018 WAIT: done_in=1 -> IDLE, done_cnt+1 in next cycle; else abort=1 -> KILL; else timer==TIMEOUT-1 -> KILL with timeout cause; else timer+1.
REQ-019 WAIT SHALL last at most TIMEOUT cycles.
REQ-020 Simultaneous done_in with abort or timer expiry: done_in wins; job counts as completed, no kill.
REQ-021 KILL: kill_out=1 for exactly one cycle, kill_ltchd set, timeout_err set if timeout cause; -> IDLE (except REQ-030).
REQ-022 done_in outside WAIT and start outside IDLE SHALL be ignored (no queueing).
REQ-023 done_cnt SHALL saturate at 255 and never wrap.
REQ-024 kill_clr SHALL clear kill_ltchd and timeout_err next cycle; set in the same cycle as kill_clr wins.
REQ-025 go_out and kill_out SHALL never be high in the same cycle.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, timer=0, go_out=0, kill_out=0, busy=0, kill_ltchd=0, timeout_err=0, done_cnt=0.
REQ-027 Reset mid-job SHALL abandon it with no kill_out pulse; first start after release behaves per REQ-017.
REQ-028 Reset release SHALL take effect on the first rising clk edge with reset_n high.

Configuration
REQ-029 Macro GO_KILL_CTRL_RETRY_EN SHALL enable one automatic retry on timeout.
REQ-030 Defined: first timeout of a job -> KILL (kill_out pulse, kill_ltchd and timeout_err NOT set) -> GO again; second timeout -> KILL with latching per REQ-021; abort never retries.
REQ-031 Not defined: every timeout latches per REQ-021, no retry logic or retry flag present.

Verification (TIMEOUT=4)
REQ-032 start pulse cycle 0, done_in cycle 3 -> go_out cycle 1 only, busy cycles 1-3, done_cnt=1 at cycle 4, no kill_out.
REQ-033 start cycle 0, no done_in -> WAIT cycles 2-5, kill_out cycle 6, kill_ltchd=1 and timeout_err=1 from cycle 7; later start ignored until kill_clr.
REQ-034 abort and done_in both high in one WAIT cycle -> done_cnt increments, kill_out stays 0; abort alone in GO -> kill_out next cycle, timeout_err=0.
REQ-035 kill_clr asserted during the KILL-state cycle -> kill_ltchd still 1 afterwards; kill_clr one cycle later -> kill_ltchd=0.
REQ-036 256 completed jobs -> done_cnt=255; reset_n low mid-WAIT -> all outputs 0 immediately, no kill_out.
REQ-037 With GO_KILL_CTRL_RETRY_EN, no done_in -> two go_out and two kill_out pulses, kill_ltchd set only after the second.
